// File: rtl/sort_pkg.sv
// sort_pkg: shared state encoding and sizing constants for sort_seq.
// Holds the FSM enum and the element count / pass count constants.
package sort_pkg;

  typedef enum logic [1:0] {
    LOAD  = 2'd0,
    SORT  = 2'd1,
    DRAIN = 2'd2
  } state_e;

  localparam int N           = 4;
  localparam int PASSES      = N - 1;
  localparam int SORT_CYCLES = (N - 1) * (N - 1);

endpackage

// File: rtl/sort_cmp_swap.sv
// sort_cmp_swap: combinational compare-swap cell, unsigned.
// Ports: a, b in; lo = smaller, hi = larger; swaps only when a > b.
module sort_cmp_swap #(
  parameter int W = 4
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic [W-1:0] lo,
  output logic [W-1:0] hi
);

  logic swap;

  // Strict compare keeps ties in place.
  assign swap = a > b;
  assign lo   = swap ? b : a;
  assign hi   = swap ? a : b;

endmodule

// File: rtl/sort_seq.sv
// sort_seq: serial 4-entry sorter, valid/ready in and out, one shared cmp cell.
// Ports: clk, rst (sync high), in_valid/in_ready/in_data, out_valid/out_ready/out_data/out_last, busy.
module sort_seq
  import sort_pkg::*;
#(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_data,
  output logic         out_last,
  output logic         busy
);

  state_e       state_q, state_d;
  logic [1:0]   li_q, li_d;
  logic [1:0]   ci_q, ci_d;
  logic [1:0]   pc_q, pc_d;
  logic [1:0]   di_q, di_d;
  logic [W-1:0] mem_q [N];
  logic [W-1:0] mem_d [N];

  logic [1:0]   ci_nx;
  logic [W-1:0] cs_lo;
  logic [W-1:0] cs_hi;

  assign ci_nx = ci_q + 2'd1;

  sort_cmp_swap #(
    .W(W)
  ) u_cs (
    .a (mem_q[ci_q]),
    .b (mem_q[ci_nx]),
    .lo(cs_lo),
    .hi(cs_hi)
  );

  always_comb begin
    state_d = state_q;
    li_d    = li_q;
    ci_d    = ci_q;
    pc_d    = pc_q;
    di_d    = di_q;
    mem_d   = mem_q;
    unique case (state_q)
      LOAD: begin
        if (in_valid) begin
          mem_d[li_q] = in_data;
          li_d        = li_q + 2'd1;
          if (li_q == 2'(N - 1)) begin
            state_d = SORT;
            ci_d    = 2'd0;
            pc_d    = 2'd0;
          end
        end
      end
      SORT: begin
        mem_d[ci_q]  = cs_lo;
        mem_d[ci_nx] = cs_hi;
        if (ci_q == 2'(N - 2)) begin
          ci_d = 2'd0;
          if (pc_q == 2'(PASSES - 1)) begin
            state_d = DRAIN;
            di_d    = 2'd0;
          end else begin
            pc_d = pc_q + 2'd1;
          end
        end else begin
          ci_d = ci_nx;
        end
      end
      DRAIN: begin
        if (out_ready) begin
          di_d = di_q + 2'd1;
          if (di_q == 2'(N - 1)) begin
            state_d = LOAD;
            li_d    = 2'd0;
          end
        end
      end
      default: state_d = LOAD;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= LOAD;
      li_q    <= 2'd0;
      ci_q    <= 2'd0;
      pc_q    <= 2'd0;
      di_q    <= 2'd0;
      for (int i = 0; i < N; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      state_q <= state_d;
      li_q    <= li_d;
      ci_q    <= ci_d;
      pc_q    <= pc_d;
      di_q    <= di_d;
      for (int i = 0; i < N; i++) begin
        mem_q[i] <= mem_d[i];
      end
    end
  end

  // rst gates in_ready so the producer sees no accept during reset.
  assign in_ready  = (state_q == LOAD) && !rst;
  assign out_valid = (state_q == DRAIN);
  assign out_last  = (state_q == DRAIN) && (di_q == 2'(N - 1));
  assign out_data  = (state_q == DRAIN) ? mem_q[di_q] : '0;
  assign busy      = (state_q != LOAD);

endmodule

// File: tb/tb_sort_seq.sv
// tb_sort_seq: scoreboard bench for sort_seq.
// Sorted expectations are queued on send and popped on each output transfer.
module tb_sort_seq;

  logic       clk;
  logic       rst;
  logic       in_valid;
  logic       in_ready;
  logic [3:0] in_data;
  logic       out_valid;
  logic       out_ready;
  logic [3:0] out_data;
  logic       out_last;
  logic       busy;

  sort_seq #(
    .W(4)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_data  (in_data),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data (out_data),
    .out_last (out_last),
    .busy     (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int nerr = 0;
  int nchk = 0;
  int cyc  = 0;
  int acc_cyc = 0;
  int nxfer = 0;
  int sort_cnt = 0;
  bit first = 1'b1;
  bit ir_bad = 1'b0;
  bit last_pend = 1'b0;
  logic [4:0] sb [$];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    nchk++;
    if (obs !== exp) begin
      nerr++;
      $display("FAIL %s: got %0d want %0d (cyc %0d)", tag, obs, exp, cyc);
    end
  endtask

  // Starts and ends at posedge+#1.
  task automatic push(input logic [3:0] v, input int gap);
    int t;
    bit done;
    repeat (gap) begin
      @(posedge clk);
      #1;
    end
    in_valid = 1'b1;
    in_data  = v;
    t = 0;
    done = 1'b0;
    while (!done) begin
      @(negedge clk);
      if (in_ready) begin
        done = 1'b1;
      end else begin
        t++;
        if (t > 100) begin
          chk("push_timeout", 1, 0);
          done = 1'b1;
        end
      end
    end
    acc_cyc = cyc;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic send_block(input logic [3:0] a, input logic [3:0] b,
                            input logic [3:0] c, input logic [3:0] d,
                            input int gmax);
    logic [3:0] v [4];
    logic [3:0] s [4];
    bit used [4];
    int m;
    v[0] = a; v[1] = b; v[2] = c; v[3] = d;
    for (int i = 0; i < 4; i++) used[i] = 1'b0;
    for (int k = 0; k < 4; k++) begin
      m = -1;
      for (int i = 0; i < 4; i++)
        if (!used[i] && (m < 0 || v[i] < v[m])) m = i;
      used[m] = 1'b1;
      s[k] = v[m];
    end
    for (int k = 0; k < 4; k++) sb.push_back({k == 3, s[k]});
    for (int k = 0; k < 4; k++)
      push(v[k], (gmax > 0) ? int'($urandom_range(0, gmax)) : 0);
  endtask

  task automatic wait_idle();
    int t;
    t = 0;
    while (sb.size() != 0 && t < 300) begin
      @(posedge clk);
      #1;
      t++;
    end
    if (sb.size() != 0) chk("drain_timeout", sb.size(), 0);
    repeat (2) begin
      @(posedge clk);
      #1;
    end
  endtask

  always @(negedge clk) begin
    logic [4:0] e;
    if (rst) begin
      first = 1'b1;
      sort_cnt = 0;
      ir_bad = 1'b0;
      last_pend = 1'b0;
    end else begin
      if (last_pend) begin
        chk("ir_back", in_ready, 1);
        last_pend = 1'b0;
      end
      if (busy && in_ready) ir_bad = 1'b1;
      if (busy && !out_valid) sort_cnt++;
      if (out_valid) begin
        if (first) begin
          chk("latency", cyc - acc_cyc, 10);
          chk("sort_cycles", sort_cnt, 9);
          first = 1'b0;
          sort_cnt = 0;
        end
        if (sb.size() == 0) begin
          chk("spurious_out", 1, 0);
        end else begin
          e = sb[0];
          chk(out_ready ? "data" : "stall_data", out_data, e[3:0]);
          chk(out_ready ? "last" : "stall_last", out_last, e[4]);
          if (out_ready) begin
            void'(sb.pop_front());
            nxfer++;
            if (e[4]) begin
              chk("ir_busy", ir_bad, 0);
              ir_bad = 1'b0;
              first = 1'b1;
              last_pend = 1'b1;
            end
          end
        end
      end
    end
  end

  initial begin
    int base;
    int t;
    rst = 1'b1;
    in_valid = 1'b0;
    in_data = 4'd0;
    out_ready = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_in_ready", in_ready, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_last", out_last, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_busy", busy, 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    chk("rel_in_ready", in_ready, 1);
    @(posedge clk);
    #1;

    send_block(4'd9, 4'd3, 4'd7, 4'd1, 0);
    wait_idle();
    send_block(4'd15, 4'd15, 4'd0, 4'd0, 0);
    wait_idle();
    send_block(4'd1, 4'd2, 4'd3, 4'd4, 0);
    wait_idle();
    send_block(4'd4, 4'd3, 4'd2, 4'd1, 0);
    wait_idle();

    base = nxfer;
    send_block(4'd5, 4'd8, 4'd2, 4'd6, 3);
    t = 0;
    while (nxfer < base + 2 && t < 200) begin
      @(posedge clk);
      #1;
      t++;
    end
    chk("stall_reach", nxfer - base, 2);
    out_ready = 1'b0;
    repeat (5) begin
      @(posedge clk);
      #1;
    end
    chk("stall_hold", nxfer - base, 2);
    out_ready = 1'b1;
    wait_idle();

    push(4'd3, 0);
    push(4'd1, 0);
    push(4'd2, 0);
    push(4'd0, 0);
    repeat (3) begin
      @(posedge clk);
      #1;
    end
    rst = 1'b1;
    @(negedge clk);
    chk("mid_rst_in_ready", in_ready, 0);
    chk("mid_rst_out_valid", out_valid, 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    chk("post_rst_in_ready", in_ready, 1);
    chk("post_rst_busy", busy, 0);
    chk("post_rst_out_valid", out_valid, 0);
    @(posedge clk);
    #1;
    send_block(4'd6, 4'd4, 4'd5, 4'd7, 0);
    wait_idle();

    send_block(4'd2, 4'd0, 4'd3, 4'd1, 0);
    send_block(4'd12, 4'd10, 4'd11, 4'd13, 0);
    wait_idle();

    chk("sb_empty", sb.size(), 0);
    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule
